// File: rtl/adc_sequencer.sv
// Sweeps ADC channels CH_BASE..CH_BASE+NUM_CH-1 and averages 2^AVG_LOG2 conversions into one sample per channel.
// Latency: sample_valid one clock after the final response of a channel; next command one clock after that.
// Backpressure: command fields hold while command_ready is low; optional ADC_SEQ_TIMEOUT_EN adds a response watchdog.
module adc_sequencer #(
    parameter int NUM_CH   = 2,
    parameter int CH_BASE  = 1,
    parameter int AVG_LOG2 = 2,
    parameter int TIMEOUT  = 1023
) (
    input  logic        clock_clk,
    input  logic        reset_sink_reset,
    input  logic        enable,
    output logic        command_valid,
    output logic [4:0]  command_channel,
    output logic        command_startofpacket,
    output logic        command_endofpacket,
    input  logic        command_ready,
    input  logic        response_valid,
    input  logic [4:0]  response_channel,
    input  logic [11:0] response_data,
    output logic        sample_valid,
    output logic [2:0]  sample_index,
    output logic [11:0] sample_data,
    output logic        seq_error
);

    localparam int AW   = 12 + AVG_LOG2;
    localparam int CW   = AVG_LOG2 + 1;
    localparam int NAVG = 1 << AVG_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CMD,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_index;
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_sample_index;
    logic [11:0]     r_sample_data;
    logic            r_seq_error;

    logic [4:0]      w_exp_ch;
    logic            w_last;
    logic            w_resp_hit;
    logic            w_resp_miss;
    logic [AW-1:0]   w_acc_sum;
    logic [CW-1:0]   w_count_inc;
    logic            w_count_full;
    logic            w_timeout;

    assign w_exp_ch     = 5'(CH_BASE) + 5'(r_index);
    assign w_last       = (r_index == 3'(NUM_CH - 1));
    assign w_resp_hit   = (r_state == S_WAIT) && response_valid && (response_channel == w_exp_ch);
    assign w_resp_miss  = (r_state == S_WAIT) && response_valid && (response_channel != w_exp_ch);
    assign w_acc_sum    = r_acc + AW'(response_data);
    assign w_count_inc  = r_count + CW'(1);
    assign w_count_full = (w_count_inc == CW'(NAVG));

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_tmo;

    // Counts WAIT cycles; zero on every entry to WAIT.
    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            r_tmo <= '0;
        end else if (r_state == S_WAIT) begin
            r_tmo <= r_tmo + TW'(1);
        end else begin
            r_tmo <= '0;
        end
    end

    assign w_timeout = (r_state == S_WAIT) && !response_valid && (r_tmo == TW'(TIMEOUT - 1));
`else
    // TIMEOUT has no role without the watchdog; the term folds to zero.
    assign w_timeout = 1'b0 & (TIMEOUT != 0);
`endif

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt           = r_state;
        command_valid         = 1'b0;
        command_channel       = 5'd0;
        command_startofpacket = 1'b0;
        command_endofpacket   = 1'b0;
        sample_valid          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_CMD: begin
                command_valid         = 1'b1;
                command_channel       = w_exp_ch;
                command_startofpacket = (r_index == 3'd0);
                command_endofpacket   = w_last;
                if (command_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_resp_hit) begin
                    w_state_nxt = w_count_full ? S_DONE : S_CMD;
                end else if (w_resp_miss || w_timeout) begin
                    w_state_nxt = S_CMD;
                end
            end
            S_DONE: begin
                sample_valid = 1'b1;
                w_state_nxt  = (w_last && !enable) ? S_IDLE : S_CMD;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_clk) begin
        if (reset_sink_reset) begin
            r_index        <= 3'd0;
            r_acc          <= '0;
            r_count        <= '0;
            r_sample_index <= 3'd0;
            r_sample_data  <= 12'd0;
            r_seq_error    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_index <= 3'd0;
                        r_acc   <= '0;
                        r_count <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_resp_hit) begin
                        r_acc   <= w_acc_sum;
                        r_count <= w_count_inc;
                        // Sample registers load as DONE is entered and hold until the next DONE.
                        if (w_count_full) begin
                            r_sample_data  <= 12'(w_acc_sum >> AVG_LOG2);
                            r_sample_index <= r_index;
                        end
                    end else if (w_resp_miss || w_timeout) begin
                        r_seq_error <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_acc   <= '0;
                    r_count <= '0;
                    r_index <= w_last ? 3'd0 : r_index + 3'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign sample_index = r_sample_index;
    assign sample_data  = r_sample_data;
    assign seq_error    = r_seq_error;

endmodule

// File: tb/tb_adc_sequencer.sv
// Randomised bench for adc_sequencer; expected samples come from plain per-channel averages of the driven data.
module tb_adc_sequencer;

    localparam int NUM_CH   = 2;
    localparam int CH_BASE  = 1;
    localparam int AVG_LOG2 = 2;
    localparam int NAVG     = 1 << AVG_LOG2;
`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int TIMEOUT  = 8;
`else
    localparam int TIMEOUT  = 1023;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        command_ready = 1'b0;
    logic        response_valid = 1'b0;
    logic [4:0]  response_channel = 5'd0;
    logic [11:0] response_data = 12'd0;
    logic        cmd_valid;
    logic [4:0]  cmd_ch;
    logic        cmd_sop;
    logic        cmd_eop;
    logic        sample_valid;
    logic [2:0]  sample_index;
    logic [11:0] sample_data;
    logic        seq_error;

    int n_checks = 0;
    int n_pass   = 0;
    int n_hs     = 0;

    adc_sequencer #(
        .NUM_CH   (NUM_CH),
        .CH_BASE  (CH_BASE),
        .AVG_LOG2 (AVG_LOG2),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clock_clk             (clk),
        .reset_sink_reset      (rst),
        .enable                (enable),
        .command_valid         (cmd_valid),
        .command_channel       (cmd_ch),
        .command_startofpacket (cmd_sop),
        .command_endofpacket   (cmd_eop),
        .command_ready         (command_ready),
        .response_valid        (response_valid),
        .response_channel      (response_channel),
        .response_data         (response_data),
        .sample_valid          (sample_valid),
        .sample_index          (sample_index),
        .sample_data           (sample_data),
        .seq_error             (seq_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && cmd_valid && command_ready) n_hs <= n_hs + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got %0d checks, want completion", n_checks);
        $fatal(1);
    end

    function automatic int avg_of(input int v[NAVG]);
        int s = 0;
        for (int i = 0; i < NAVG; i++) s += v[i];
        return s / NAVG;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        command_ready = 1'b0;
        response_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for a command, accepts it for one cycle and reports what was seen.
    task automatic issue(output bit ok, output logic [4:0] ch, output logic sop, output logic eop);
        ok = 1'b0; ch = 5'd0; sop = 1'b0; eop = 1'b0;
        for (int i = 0; i < 50 && !cmd_valid; i++) tick();
        if (cmd_valid) begin
            ch = cmd_ch; sop = cmd_sop; eop = cmd_eop;
            command_ready = 1'b1;
            tick();
            command_ready = 1'b0;
            ok = 1'b1;
        end
    endtask

    task automatic respond(input logic [4:0] ch, input logic [11:0] d, input int delay);
        repeat (delay) tick();
        response_valid = 1'b1;
        response_channel = ch;
        response_data = d;
        tick();
        response_valid = 1'b0;
        response_channel = 5'($urandom);
        response_data = 12'($urandom);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({cmd_valid, cmd_ch, cmd_sop, cmd_eop, sample_valid, sample_index, sample_data, seq_error} !== '0) begin
            $display("FAIL reset_outputs: got valid=%b ch=%0d sop=%b eop=%b sv=%b si=%0d sd=%0d err=%b, want all 0",
                     cmd_valid, cmd_ch, cmd_sop, cmd_eop, sample_valid, sample_index, sample_data, seq_error);
        end else n_pass++;
    endtask

    task automatic test_sweep();
        bit ok; logic [4:0] ch; logic sop; logic eop;
        do_reset();
        enable = 1'b1;
        for (int sw = 0; sw < 4; sw++) begin
            for (int idx = 0; idx < NUM_CH; idx++) begin
                int vals[NAVG];
                for (int k = 0; k < NAVG; k++) begin
                    if (sw == 0) vals[k] = (idx == 0) ? 100 + k : 4095;
                    else vals[k] = int'($urandom_range(0, 4095));
                    issue(ok, ch, sop, eop);
                    n_checks++;
                    if (!ok || ch !== 5'(CH_BASE + idx) || sop !== 1'(idx == 0) || eop !== 1'(idx == NUM_CH - 1)) begin
                        $display("FAIL sweep_cmd sw%0d idx%0d k%0d: got ok=%b ch=%0d sop=%b eop=%b, want ch=%0d sop=%b eop=%b",
                                 sw, idx, k, ok, ch, sop, eop, CH_BASE + idx, idx == 0, idx == NUM_CH - 1);
                    end else n_pass++;
                    respond(5'(CH_BASE + idx), 12'(vals[k]), (sw == 0) ? 0 : int'($urandom_range(0, 3)));
                    if (k < NAVG - 1) begin
                        n_checks++;
                        if (sample_valid !== 1'b0) begin
                            $display("FAIL sweep_early_sample sw%0d idx%0d k%0d: got sample_valid=%b, want 0", sw, idx, k, sample_valid);
                        end else n_pass++;
                    end
                end
                n_checks++;
                if (sample_valid !== 1'b1 || sample_index !== 3'(idx) || sample_data !== 12'(avg_of(vals))) begin
                    $display("FAIL sweep_sample sw%0d idx%0d: got sv=%b si=%0d sd=%0d, want sv=1 si=%0d sd=%0d",
                             sw, idx, sample_valid, sample_index, sample_data, idx, avg_of(vals));
                end else n_pass++;
                tick();
                n_checks++;
                if (sample_valid !== 1'b0 || sample_data !== 12'(avg_of(vals)) || cmd_valid !== 1'b1) begin
                    $display("FAIL sweep_after_done sw%0d idx%0d: got sv=%b sd=%0d cv=%b, want sv=0 sd=%0d cv=1",
                             sw, idx, sample_valid, sample_data, cmd_valid, avg_of(vals));
                end else n_pass++;
            end
        end
        enable = 1'b0;
    endtask

    task automatic test_ready_hold();
        logic [7:0] snap;
        int hs0;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 10 && !cmd_valid; i++) tick();
        snap = {cmd_valid, cmd_ch, cmd_sop, cmd_eop};
        hs0 = n_hs;
        n_checks++;
        if (snap !== {1'b1, 5'(CH_BASE), 1'b1, 1'b0}) begin
            $display("FAIL hold_first_cmd: got %b, want %b", snap, {1'b1, 5'(CH_BASE), 1'b1, 1'b0});
        end else n_pass++;
        for (int c = 0; c < 5; c++) begin
            command_ready = 1'b0;
            tick();
            n_checks++;
            if ({cmd_valid, cmd_ch, cmd_sop, cmd_eop} !== snap) begin
                $display("FAIL hold_stable c%0d: got %b, want %b", c, {cmd_valid, cmd_ch, cmd_sop, cmd_eop}, snap);
            end else n_pass++;
        end
        command_ready = 1'b1;
        tick();
        command_ready = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (n_hs - hs0 !== 1 || cmd_valid !== 1'b0) begin
            $display("FAIL hold_one_cmd: got handshakes=%0d cv=%b, want handshakes=1 cv=0", n_hs - hs0, cmd_valid);
        end else n_pass++;
    endtask

    task automatic test_bad_channel();
        bit ok; logic [4:0] ch; logic sop; logic eop;
        int vals[NAVG];
        do_reset();
        enable = 1'b1;
        issue(ok, ch, sop, eop);
        respond(5'(CH_BASE + 2), 12'($urandom_range(1000, 4095)), 0);
        n_checks++;
        if (seq_error !== 1'b1 || sample_valid !== 1'b0 || cmd_valid !== 1'b1) begin
            $display("FAIL bad_ch_error: got err=%b sv=%b cv=%b, want err=1 sv=0 cv=1", seq_error, sample_valid, cmd_valid);
        end else n_pass++;
        for (int k = 0; k < NAVG; k++) begin
            vals[k] = int'($urandom_range(0, 4095));
            issue(ok, ch, sop, eop);
            n_checks++;
            if (!ok || ch !== 5'(CH_BASE) || sop !== 1'b1) begin
                $display("FAIL bad_ch_reissue k%0d: got ok=%b ch=%0d sop=%b, want ch=%0d sop=1", k, ok, ch, sop, CH_BASE);
            end else n_pass++;
            respond(5'(CH_BASE), 12'(vals[k]), int'($urandom_range(0, 2)));
        end
        n_checks++;
        if (sample_valid !== 1'b1 || sample_index !== 3'd0 || sample_data !== 12'(avg_of(vals)) || seq_error !== 1'b1) begin
            $display("FAIL bad_ch_sample: got sv=%b si=%0d sd=%0d err=%b, want sv=1 si=0 sd=%0d err=1",
                     sample_valid, sample_index, sample_data, seq_error, avg_of(vals));
        end else n_pass++;
    endtask

    task automatic test_enable_drop();
        bit ok; logic [4:0] ch; logic sop; logic eop;
        int n_samples = 0;
        int n_cv = 0;
        do_reset();
        enable = 1'b1;
        for (int idx = 0; idx < NUM_CH; idx++) begin
            int vals[NAVG];
            for (int k = 0; k < NAVG; k++) begin
                vals[k] = int'($urandom_range(0, 4095));
                issue(ok, ch, sop, eop);
                enable = 1'b0;
                respond(5'(CH_BASE + idx), 12'(vals[k]), int'($urandom_range(0, 2)));
            end
            if (sample_valid === 1'b1) n_samples++;
            n_checks++;
            if (sample_valid !== 1'b1 || sample_index !== 3'(idx) || sample_data !== 12'(avg_of(vals))) begin
                $display("FAIL drop_sample idx%0d: got sv=%b si=%0d sd=%0d, want sv=1 si=%0d sd=%0d",
                         idx, sample_valid, sample_index, sample_data, idx, avg_of(vals));
            end else n_pass++;
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (cmd_valid === 1'b1) n_cv++;
        end
        n_checks++;
        if (n_samples !== NUM_CH || n_cv !== 0) begin
            $display("FAIL drop_stop: got samples=%0d cmd_cycles=%0d, want samples=%0d cmd_cycles=0", n_samples, n_cv, NUM_CH);
        end else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok; logic [4:0] ch; logic sop; logic eop;
        int hs0;
        do_reset();
        enable = 1'b1;
        issue(ok, ch, sop, eop);
        issue(ok, ch, sop, eop);
        rst = 1'b1;
        enable = 1'b0;
        tick();
        n_checks++;
        if ({cmd_valid, cmd_ch, cmd_sop, cmd_eop, sample_valid, sample_index, sample_data, seq_error} !== '0) begin
            $display("FAIL midreset_outputs: got cv=%b ch=%0d sv=%b si=%0d sd=%0d err=%b, want all 0",
                     cmd_valid, cmd_ch, sample_valid, sample_index, sample_data, seq_error);
        end else n_pass++;
        rst = 1'b0;
        hs0 = n_hs;
        respond(5'(CH_BASE), 12'd777, 0);
        repeat (3) tick();
        n_checks++;
        if (sample_valid !== 1'b0 || seq_error !== 1'b0 || cmd_valid !== 1'b0 || n_hs !== hs0) begin
            $display("FAIL midreset_ignore: got sv=%b err=%b cv=%b hs=%0d, want sv=0 err=0 cv=0 hs=0",
                     sample_valid, seq_error, cmd_valid, n_hs - hs0);
        end else n_pass++;
        enable = 1'b1;
        issue(ok, ch, sop, eop);
        n_checks++;
        if (!ok || ch !== 5'(CH_BASE) || sop !== 1'b1) begin
            $display("FAIL midreset_restart: got ok=%b ch=%0d sop=%b, want ch=%0d sop=1", ok, ch, sop, CH_BASE);
        end else n_pass++;
    endtask

`ifdef ADC_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok; logic [4:0] ch; logic sop; logic eop;
        int vals[NAVG];
        do_reset();
        enable = 1'b1;
        vals[0] = int'($urandom_range(0, 4095));
        issue(ok, ch, sop, eop);
        respond(5'(CH_BASE), 12'(vals[0]), 0);
        issue(ok, ch, sop, eop);
        repeat (TIMEOUT - 1) tick();
        n_checks++;
        if (seq_error !== 1'b0 || cmd_valid !== 1'b0) begin
            $display("FAIL tmo_early: got err=%b cv=%b, want err=0 cv=0", seq_error, cmd_valid);
        end else n_pass++;
        tick();
        n_checks++;
        if (seq_error !== 1'b1 || cmd_valid !== 1'b1 || cmd_ch !== 5'(CH_BASE)) begin
            $display("FAIL tmo_fire: got err=%b cv=%b ch=%0d, want err=1 cv=1 ch=%0d", seq_error, cmd_valid, cmd_ch, CH_BASE);
        end else n_pass++;
        for (int k = 1; k < NAVG; k++) begin
            vals[k] = int'($urandom_range(0, 4095));
            issue(ok, ch, sop, eop);
            respond(5'(CH_BASE), 12'(vals[k]), 0);
        end
        n_checks++;
        if (sample_valid !== 1'b1 || sample_data !== 12'(avg_of(vals))) begin
            $display("FAIL tmo_count_kept: got sv=%b sd=%0d, want sv=1 sd=%0d", sample_valid, sample_data, avg_of(vals));
        end else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
        test_ready_hold();
        test_bad_channel();
        test_enable_drop();
        test_reset_mid();
`ifdef ADC_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
